// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and helpers for the banked synchronous RAM:
//                sweep/idle state encoding and bank-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Two-state controller: CLEAR sweeps zeros through every row, IDLE serves accesses
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Number of address bits needed to select one of num_banks banks
    function automatic int bank_idx_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // Bank-index width for the default four-bank configuration
    localparam int C_BANK_IDX_W_DEFAULT = bank_idx_w(4);

    // Width of one byte lane
    localparam int C_BYTE_W = 8;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bank
//  Description : Single-port synchronous RAM bank with per-byte write enables
//                and a registered read port that holds its value between reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_bank #(
    parameter int ROW_W      = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [ROW_W-1:0]        i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    import ram_pkg::*;

    localparam int C_DEPTH = 2 ** ROW_W;
    localparam int C_BE_W  = DATA_WIDTH / C_BYTE_W;

    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-lane write: only lanes with an enable set are updated
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int lane = 0; lane < C_BE_W; lane++) begin
                if (i_be[lane]) begin
                    r_mem[i_addr][lane*C_BYTE_W +: C_BYTE_W] <= i_wdata[lane*C_BYTE_W +: C_BYTE_W];
                end
            end
        end
    end

    // Registered read; the output holds its last value when no read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : ram_bank
`default_nettype wire

// File: rtl/banked_sync_ram.sv
`default_nettype none
// ============================================================================
//  Module      : banked_sync_ram
//  Description : Word-addressed RAM split into NUM_BANKS banks selected by the
//                top address bits. Byte-enable writes, 1-cycle read latency,
//                and a full-memory clear sweep (one row of every bank per
//                cycle) run after reset or on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module banked_sync_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    clear,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid
);
    import ram_pkg::*;

    localparam int C_BANK_W = bank_idx_w(NUM_BANKS);
    localparam int C_ROW_W  = ADDR_WIDTH - C_BANK_W;
    localparam int C_BE_W   = DATA_WIDTH / C_BYTE_W;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [C_ROW_W-1:0]      r_cnt;
    logic                    w_ready;
    logic                    w_clearing;
    logic                    w_accept;
    logic [C_BANK_W-1:0]     w_bank_idx;
    logic [C_ROW_W-1:0]      w_row;
    logic [C_BANK_W-1:0]     r_rd_bank;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   w_bank_rdata [NUM_BANKS];

    assign w_bank_idx = addr[ADDR_WIDTH-1 -: C_BANK_W];
    assign w_row      = addr[C_ROW_W-1:0];
    assign w_clearing = (r_state == CLEAR);
    // Reset wins over any request presented in the same cycle
    assign w_accept   = req & w_ready & ~rst;

    // State register: reset always (re)starts the clear sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: sweep ends after the last row; clear is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (r_cnt == {C_ROW_W{1'b1}}) w_state_nxt = IDLE;
            IDLE:    if (clear)                    w_state_nxt = CLEAR;
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Outputs of the state machine: accesses are only accepted in IDLE
    always_comb begin
        w_ready = (r_state == IDLE);
    end

    // Sweep row counter: advances in CLEAR, parked at zero otherwise so each sweep starts at row 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clearing) begin
            r_cnt <= r_cnt + C_ROW_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Read-response tracking: remember which bank answered and flag the result for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid  <= 1'b0;
            r_rd_bank <= '0;
        end else begin
            r_rvalid <= w_accept & ~we;
            if (w_accept && !we) begin
                r_rd_bank <= w_bank_idx;
            end
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic                  w_sel;
            logic                  w_we;
            logic                  w_re;
            logic [C_BE_W-1:0]     w_be;
            logic [C_ROW_W-1:0]    w_addr;
            logic [DATA_WIDTH-1:0] w_wdata;

            // During the sweep every bank writes zero to the same row in parallel
            assign w_sel   = (w_bank_idx == C_BANK_W'(b));
            assign w_we    = w_clearing | (w_accept & we & w_sel);
            assign w_re    = w_accept & ~we & w_sel;
            assign w_be    = w_clearing ? {C_BE_W{1'b1}} : be;
            assign w_addr  = w_clearing ? r_cnt : w_row;
            assign w_wdata = w_clearing ? '0 : wdata;

            ram_bank #(
                .ROW_W      (C_ROW_W),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_bank (
                .clk     (clk),
                .rst     (rst),
                .i_we    (w_we),
                .i_re    (w_re),
                .i_be    (w_be),
                .i_addr  (w_addr),
                .i_wdata (w_wdata),
                .o_rdata (w_bank_rdata[b])
            );
        end
    endgenerate

    assign ready  = w_ready;
    assign rvalid = r_rvalid;
    // Bank outputs hold between reads, so muxing by the last-read bank keeps rdata stable
    assign rdata  = w_bank_rdata[r_rd_bank];

endmodule : banked_sync_ram
`default_nettype wire

// File: doc/banked_sync_ram.md
BANKED_SYNC_RAM -- requirements
Module: banked_sync_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning total word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits; legal values are multiples of 8.
REQ-003 SHALL have parameter NUM_BANKS, default 4, meaning bank count; legal values are powers of 2 from 2 to 2^(ADDR_WIDTH-1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, 1 bit: access request.
REQ-007 SHALL have port we, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-008 SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-009 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port be, input, DATA_WIDTH/8 bits: byte enables for writes.
REQ-011 SHALL have port clear, input, 1 bit: single-cycle request to zero the whole memory.
REQ-012 SHALL have port ready, output, 1 bit: block can accept an access.
REQ-013 SHALL have port rdata, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port rvalid, output, 1 bit: rdata carries the result of a read.

Function
REQ-015 SHALL select the bank from addr[ADDR_WIDTH-1 -: log2(NUM_BANKS)] and the row from the remaining low bits; bank depth is 2^(ADDR_WIDTH-log2(NUM_BANKS)).
REQ-016 SHALL accept an access in a cycle where req=1 and ready=1, and ignore req otherwise (no queuing).
REQ-017 SHALL, on an accepted write, update only the bytes whose be bit is 1 in the selected bank row; be=0 leaves memory unchanged.
REQ-018 SHALL, on an accepted read, drive rdata with the addressed word and rvalid=1 on the next cycle (latency 1).
REQ-019 SHALL hold rvalid=0 in every cycle that does not follow an accepted read; rdata holds its last value while rvalid=0.
REQ-020 SHALL use a two-state machine, CLEAR and IDLE; ready=1 only in IDLE.
REQ-021 SHALL, in CLEAR, write zero to row cnt of all banks in parallel each cycle, incrementing cnt from 0; after the last row it SHALL go to IDLE, giving a clear time of exactly 2^(ADDR_WIDTH-log2(NUM_BANKS)) cycles.
REQ-022 SHALL go from IDLE to CLEAR on clear=1 with cnt reset to 0.
REQ-023 SHALL, when clear=1 and an access is accepted in the same cycle, perform the access and start CLEAR next cycle; a read in that case still returns the pre-clear data with rvalid=1.
REQ-024 SHALL ignore clear while in CLEAR; the sweep SHALL NOT restart.
REQ-025 SHALL return the newly written data on a read issued in the cycle after a write to the same address.

Reset
REQ-026 SHALL, on rst=1, set state=CLEAR, cnt=0, ready=0, rvalid=0, rdata=0; memory contents are then zeroed by the CLEAR sweep.
REQ-027 SHALL, on rst asserted mid-sweep or mid-read, abort the operation, drive rvalid=0 next cycle and restart the sweep from row 0.

Structure
REQ-028 SHALL place the state enum (CLEAR, IDLE) and a bank-index-width helper constant in the shared package ram_pkg.
REQ-029 SHALL instantiate NUM_BANKS copies of one sub-module, ram_bank: a single-port synchronous bank with byte-enable write and registered read.
REQ-030 SHALL use a separate rdata output, with no bidirectional data port.

Verification (ADDR_WIDTH=8, DATA_WIDTH=16, NUM_BANKS=4, bank depth 64)
REQ-031 SHALL check reset: rst high 2 cycles then low -> ready=0 for exactly 64 cycles, then 1; reads of 0x00, 0x7F, 0xFF return 0x0000.
REQ-032 SHALL check the bank boundary: write 0xA5A5 to 0x3F and 0x1234 to 0x40, then read both -> 0xA5A5 then 0x1234, each with rvalid one cycle after acceptance.
REQ-033 SHALL check byte enables: write 0xFFFF to 0x10, then write 0x0000 with be=2'b01 -> read 0x10 returns 0xFF00.
REQ-034 SHALL check clear with a simultaneous read: with 0xBEEF at 0xC3, read 0xC3 with clear=1 -> rvalid=1 and rdata=0xBEEF next cycle, ready=0 for 64 cycles, then read 0xC3 returns 0x0000.
REQ-035 SHALL check req ignored and reset mid-sweep: req=1 during CLEAR -> no rvalid and no write; rst at sweep cycle 30 -> ready stays 0 for a fresh 64 cycles.
